// File: rtl/tl_dmi_protocol_monitor.sv
// Passive TileLink-UL protocol monitor for the debug module DMI slave port: sticky error flags.
// Optional macro TL_MONITOR_ASSERT_EN adds non-fatal immediate assertions for every check.

`ifdef TL_MONITOR_ASSERT_EN
module tl_dmi_protocol_monitor_checker (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] err_vec
);

    function automatic string check_name(input int idx);
        case (idx)
            0:       check_name = "a_opcode_illegal";
            1:       check_name = "a_misaligned";
            2:       check_name = "a_unstable";
            3:       check_name = "d_opcode_illegal";
            4:       check_name = "d_mismatch";
            5:       check_name = "d_unexpected";
            6:       check_name = "a_overflow";
            7:       check_name = "d_unstable";
            8:       check_name = "timeout";
            default: check_name = "unknown";
        endcase
    endfunction

    // Report every check that fires in the cycle it is detected; never stops simulation.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                assert (!err_vec[i])
                else $warning("tl_dmi_protocol_monitor: %s at %0t", check_name(i), $time);
            end
        end
    end

endmodule
`endif

module tl_dmi_protocol_monitor #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_a_ready,
    input  logic              io_in_a_valid,
    input  logic [2:0]        io_in_a_bits_opcode,
    input  logic [ADDR_W-1:0] io_in_a_bits_address,
    input  logic              io_in_d_ready,
    input  logic              io_in_d_valid,
    input  logic [2:0]        io_in_d_bits_opcode,
    output logic [8:0]        err_flags,
    output logic              err_any,
    output logic              inflight
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    function automatic logic a_opcode_legal(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd4: a_opcode_legal = 1'b1;
            default:          a_opcode_legal = 1'b0;
        endcase
    endfunction

    function automatic logic d_opcode_legal(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: d_opcode_legal = 1'b1;
            default:    d_opcode_legal = 1'b0;
        endcase
    endfunction

    logic              inflight_r;
    logic              stored_is_get_r;
    logic              a_stall_r;
    logic [2:0]        a_op_prev_r;
    logic [ADDR_W-1:0] a_addr_prev_r;
    logic              d_stall_r;
    logic [2:0]        d_op_prev_r;
    logic [8:0]        err_flags_r;

    logic              a_fire_s;
    logic              d_fire_s;
    logic              a_is_get_s;
    logic              exp_get_s;
    logic              timeout_s;
    logic [8:0]        err_s;
    logic              inflight_nxt_s;
    logic              is_get_nxt_s;

    assign a_fire_s   = io_in_a_valid & io_in_a_ready;
    assign d_fire_s   = io_in_d_valid & io_in_d_ready;
    assign a_is_get_s = (io_in_a_bits_opcode == 3'd4);
    // Response is matched to the stored request, or to the same-cycle request on pass-through.
    assign exp_get_s  = inflight_r ? stored_is_get_r : a_is_get_s;

    // Per-cycle protocol checks on current inputs plus recorded history.
    always_comb begin
        err_s    = 9'd0;
        err_s[0] = io_in_a_valid & ~a_opcode_legal(io_in_a_bits_opcode);
        err_s[1] = io_in_a_valid & (io_in_a_bits_address[1:0] != 2'd0);
        err_s[2] = a_stall_r & (~io_in_a_valid
                              | (io_in_a_bits_opcode != a_op_prev_r)
                              | (io_in_a_bits_address != a_addr_prev_r));
        err_s[3] = io_in_d_valid & ~d_opcode_legal(io_in_d_bits_opcode);
        err_s[4] = d_fire_s & (inflight_r | a_fire_s)
                 & (io_in_d_bits_opcode != {2'd0, exp_get_s});
        err_s[5] = d_fire_s & ~inflight_r & ~a_fire_s;
        err_s[6] = a_fire_s & inflight_r & ~d_fire_s;
        err_s[7] = d_stall_r & (~io_in_d_valid | (io_in_d_bits_opcode != d_op_prev_r));
        err_s[8] = timeout_s;
    end

    // Outstanding-request tracking; a same-cycle pass-through leaves nothing outstanding.
    always_comb begin
        inflight_nxt_s = inflight_r;
        is_get_nxt_s   = stored_is_get_r;
        if (a_fire_s && !(d_fire_s && !inflight_r)) begin
            inflight_nxt_s = 1'b1;
            is_get_nxt_s   = a_is_get_s;
        end else if (d_fire_s) begin
            inflight_nxt_s = 1'b0;
        end else begin
            inflight_nxt_s = inflight_r;
        end
    end

    // Tracking state, handshake history and sticky flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_r      <= 1'b0;
            stored_is_get_r <= 1'b0;
            a_stall_r       <= 1'b0;
            a_op_prev_r     <= 3'd0;
            a_addr_prev_r   <= '0;
            d_stall_r       <= 1'b0;
            d_op_prev_r     <= 3'd0;
            err_flags_r     <= 9'd0;
        end else begin
            inflight_r      <= inflight_nxt_s;
            stored_is_get_r <= is_get_nxt_s;
            a_stall_r       <= io_in_a_valid & ~io_in_a_ready;
            a_op_prev_r     <= io_in_a_bits_opcode;
            a_addr_prev_r   <= io_in_a_bits_address;
            d_stall_r       <= io_in_d_valid & ~io_in_d_ready;
            d_op_prev_r     <= io_in_d_bits_opcode;
            err_flags_r     <= err_flags_r | err_s;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_watchdog
            localparam logic [CNT_W-1:0] WD_MAX = CNT_W'(TIMEOUT);
            logic [CNT_W-1:0] wd_cnt_r;

            // Counts cycles spent outstanding without a response, saturating at the limit.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    wd_cnt_r <= '0;
                end else if (!inflight_r || d_fire_s) begin
                    wd_cnt_r <= '0;
                end else if (wd_cnt_r != WD_MAX) begin
                    wd_cnt_r <= wd_cnt_r + CNT_W'(1);
                end else begin
                    wd_cnt_r <= wd_cnt_r;
                end
            end

            assign timeout_s = inflight_r & (wd_cnt_r == WD_MAX);
        end else begin : g_no_watchdog
            assign timeout_s = 1'b0;
        end
    endgenerate

    assign err_flags = err_flags_r;
    assign err_any   = |err_flags_r;
    assign inflight  = inflight_r;

`ifdef TL_MONITOR_ASSERT_EN
    tl_dmi_protocol_monitor_checker u_checker (
        .clock   (clock),
        .reset   (reset),
        .err_vec (err_s)
    );
`endif

endmodule

// File: tb/tb_tl_dmi_protocol_monitor.sv
// Self-checking bench for tl_dmi_protocol_monitor: vector table plus hand-written timeout/reset sequences.
module tb_tl_dmi_protocol_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       a_ready, a_valid, d_ready, d_valid;
    logic [2:0] a_op, d_op;
    logic [6:0] a_addr;
    logic [8:0] err_flags;
    logic       err_any, inflight;

    typedef struct {
        logic       rst;
        logic       av;
        logic       ar;
        logic [2:0] aop;
        logic [6:0] addr;
        logic       dv;
        logic       dr;
        logic [2:0] dop;
        logic [8:0] ef;
        logic       ei;
    } vec_t;

    typedef struct {
        logic [8:0] ef;
        logic       ei;
    } exp_t;

    exp_t exp_q[$];
    vec_t tbl[22];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    tl_dmi_protocol_monitor #(.ADDR_W(7), .TIMEOUT(64)) dut (
        .clock                (clock),
        .reset                (reset),
        .io_in_a_ready        (a_ready),
        .io_in_a_valid        (a_valid),
        .io_in_a_bits_opcode  (a_op),
        .io_in_a_bits_address (a_addr),
        .io_in_d_ready        (d_ready),
        .io_in_d_valid        (d_valid),
        .io_in_d_bits_opcode  (d_op),
        .err_flags            (err_flags),
        .err_any              (err_any),
        .inflight             (inflight)
    );

    function automatic vec_t mk(logic rst, logic av, logic ar, logic [2:0] aop, logic [6:0] addr,
                                logic dv, logic dr, logic [2:0] dop, logic [8:0] ef, logic ei);
        vec_t v;
        v.rst = rst; v.av = av; v.ar = ar; v.aop = aop; v.addr = addr;
        v.dv = dv; v.dr = dr; v.dop = dop; v.ef = ef; v.ei = ei;
        return v;
    endfunction

    task automatic drive(logic av, logic ar, logic [2:0] aop, logic [6:0] addr,
                         logic dv, logic dr, logic [2:0] dop);
        a_valid = av; a_ready = ar; a_op = aop; a_addr = addr;
        d_valid = dv; d_ready = dr; d_op = dop;
    endtask

    task automatic do_reset();
        @(negedge clock);
        drive(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 3'd0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
    endtask

    task automatic check(string name);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            n_vec++;
            if (err_flags !== e.ef || inflight !== e.ei || err_any !== (|e.ef)) begin
                n_err++;
                $display("FAIL %s: flags=%h inflight=%b any=%b, expected flags=%h inflight=%b any=%b",
                         name, err_flags, inflight, err_any, e.ef, e.ei, |e.ef);
            end
        end
    endtask

    // Drive one cycle at the falling edge, record expectation, compare after the rising edge.
    task automatic cycle(logic av, logic ar, logic [2:0] aop, logic [6:0] addr,
                         logic dv, logic dr, logic [2:0] dop, logic [8:0] ef, logic ei, string name);
        exp_t e;
        @(negedge clock);
        drive(av, ar, aop, addr, dv, dr, dop);
        e.ef = ef; e.ei = ei;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check(name);
    endtask

    initial begin
        exp_t e;
        drive(1'b0, 1'b0, 3'd0, 7'd0, 1'b0, 1'b0, 3'd0);

        //                rst   av    ar    aop   addr    dv    dr    dop   flags    infl
        tbl[0]  = mk(1'b1, 1'b1, 1'b1, 3'd4, 7'h10, 1'b1, 1'b1, 3'd1, 9'h000, 1'b0); // get pass-through
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 3'd0, 7'h44, 1'b1, 1'b1, 3'd1, 9'h010, 1'b0); // put, wrong d op
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h010, 1'b0);
        tbl[4]  = mk(1'b1, 1'b1, 1'b1, 3'd3, 7'h06, 1'b0, 1'b0, 3'd0, 9'h003, 1'b1); // bad op + misaligned
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h003, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1, 3'd0, 9'h003, 1'b0);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 3'd4, 7'h10, 1'b0, 1'b0, 3'd0, 9'h000, 1'b0); // A stall
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 3'd4, 7'h14, 1'b0, 1'b0, 3'd0, 9'h004, 1'b0); // address moved
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h004, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1, 3'd0, 9'h020, 1'b0); // unexpected D
        tbl[11] = mk(1'b1, 1'b1, 1'b1, 3'd4, 7'h00, 1'b1, 1'b0, 3'd1, 9'h000, 1'b1); // get, D stalled
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1, 3'd1, 9'h000, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 3'd0, 7'h08, 1'b0, 1'b0, 3'd0, 9'h000, 1'b1); // put outstanding
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b0, 3'd0, 9'h000, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h080, 1'b1); // D valid dropped
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1, 3'd1, 9'h090, 1'b0); // data ack for put
        tbl[17] = mk(1'b1, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b0, 3'd5, 9'h008, 1'b0); // bad D op
        tbl[18] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h088, 1'b0);
        tbl[19] = mk(1'b1, 1'b1, 1'b1, 3'd4, 7'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b1); // get outstanding
        tbl[20] = mk(1'b0, 1'b1, 1'b1, 3'd0, 7'h04, 1'b1, 1'b1, 3'd1, 9'h000, 1'b1); // retire get, store put
        tbl[21] = mk(1'b0, 1'b0, 1'b0, 3'd0, 7'h00, 1'b1, 1'b1, 3'd0, 9'h000, 1'b0);

        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;
        e.ef = 9'h000; e.ei = 1'b0;
        exp_q.push_back(e);
        check("reset_state");

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].av, tbl[i].ar, tbl[i].aop, tbl[i].addr, tbl[i].dv, tbl[i].dr, tbl[i].dop,
                  tbl[i].ef, tbl[i].ei, $sformatf("vec%0d", i));
        end

        // Hung request: watchdog quiet early, overflow on a second request, timeout later.
        do_reset();
        cycle(1'b1, 1'b1, 3'd4, 7'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b1, "hung_accept");
        for (int i = 0; i < 59; i++) begin
            cycle(1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b1, "hung_wait");
        end
        cycle(1'b1, 1'b1, 3'd4, 7'h20, 1'b0, 1'b0, 3'd0, 9'h040, 1'b1, "overflow");
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            drive(1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0);
        end
        #1;
        e.ef = 9'h140; e.ei = 1'b1;
        exp_q.push_back(e);
        check("timeout");

        // Asynchronous reset between clock edges clears everything at once.
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        e.ef = 9'h000; e.ei = 1'b0;
        exp_q.push_back(e);
        check("async_reset");
        reset = 1'b0;
        cycle(1'b0, 1'b0, 3'd0, 7'h00, 1'b0, 1'b0, 3'd0, 9'h000, 1'b0, "post_reset_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
